// File: rtl/mips_core.sv
`default_nettype none
// ============================================================================
//  Module      : mips_core
//  Description : Multicycle 32-bit MIPS-I subset core with a five-state
//                control FSM, an internal 32x32 register file and
//                single-cycle-latency instruction/data memory ports.
//  Revision    : 1.0  initial release
// ============================================================================

module mips_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Z_R,
    output logic [31:0] IM_ADDR,
    input  logic [31:0] IM_DATA,
    output logic        DM_WE,
    output logic [31:0] DM_ADDR,
    output logic [31:0] DM_WR_DATA,
    input  logic [31:0] DM_RD_DATA
);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_J     = 6'h02;

    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_alu_out;
    logic [31:0] r_dm_addr;
    logic [31:0] r_dm_wr_data;
    logic        r_dm_we;
    logic [31:0] r_rf [32];

    logic [5:0]  w_op;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_imm_sext;
    logic [31:0] w_mem_addr;
    logic [31:0] w_r_result;
    logic        w_r_valid;
    logic [4:0]  w_wb_dest;
    logic [31:0] w_wb_data;

    assign w_op       = r_ir[31:26];
    assign w_rt       = r_ir[20:16];
    assign w_rd       = r_ir[15:11];
    assign w_funct    = r_ir[5:0];
    assign w_imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_mem_addr = r_a + w_imm_sext;
    assign w_wb_dest  = (w_op == c_OP_RTYPE) ? w_rd : w_rt;
    assign w_wb_data  = (w_op == c_OP_LW) ? DM_RD_DATA : r_alu_out;

    always_comb begin
        w_r_result = '0;
        w_r_valid  = 1'b1;
        case (w_funct)
            c_FN_ADD: w_r_result = r_a + r_b;
            c_FN_SUB: w_r_result = r_a - r_b;
            c_FN_AND: w_r_result = r_a & r_b;
            c_FN_OR:  w_r_result = r_a | r_b;
            c_FN_SLT: w_r_result = ($signed(r_a) < $signed(r_b)) ? 32'd1 : 32'd0;
            default:  w_r_valid  = 1'b0;
        endcase
    end

    assign IM_ADDR    = r_pc;
    assign DM_ADDR    = r_dm_addr;
    assign DM_WR_DATA = r_dm_wr_data;
    // Gate with reset so a store caught mid-MEM by reset never reaches memory.
    assign DM_WE      = r_dm_we & ~Z_R;

    always_ff @(posedge CLK) begin
        if (Z_R) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_ir         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_alu_out    <= '0;
            r_dm_we      <= 1'b0;
            r_dm_addr    <= '0;
            r_dm_wr_data <= '0;
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_ir    <= IM_DATA;
                    r_a     <= r_rf[IM_DATA[25:21]];
                    r_b     <= r_rf[IM_DATA[20:16]];
                    r_pc    <= r_pc + 32'd4;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_state <= S_FETCH;
                    case (w_op)
                        c_OP_RTYPE: begin
                            if (w_r_valid) begin
                                r_alu_out <= w_r_result;
                                r_state   <= S_WB;
                            end
                        end
                        c_OP_ADDI: begin
                            r_alu_out <= w_mem_addr;
                            r_state   <= S_WB;
                        end
                        c_OP_LW, c_OP_SW: begin
                            r_alu_out <= w_mem_addr;
                            r_dm_addr <= w_mem_addr;
                            if (w_op == c_OP_SW) begin
                                r_dm_we      <= 1'b1;
                                r_dm_wr_data <= r_b;
                            end
                            r_state   <= S_MEM;
                        end
                        c_OP_BEQ: begin
                            // PC already points past the branch here.
                            if (r_a == r_b) begin
                                r_pc <= r_pc + {w_imm_sext[29:0], 2'b00};
                            end
                        end
                        c_OP_J: begin
                            r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    r_dm_we <= 1'b0;
                    r_state <= (w_op == c_OP_LW) ? S_WB : S_FETCH;
                end
                S_WB: begin
                    if (w_wb_dest != 5'd0) begin
                        r_rf[w_wb_dest] <= w_wb_data;
                    end
                    r_state <= S_FETCH;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_core
//  Description : Self-checking bench for mips_core with instruction/data
//                memory models and an instruction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_mips_core;

    logic        CLK = 1'b0;
    logic        Z_R = 1'b1;
    logic [31:0] IM_ADDR;
    logic [31:0] IM_DATA;
    logic        DM_WE;
    logic [31:0] DM_ADDR;
    logic [31:0] DM_WR_DATA;
    logic [31:0] DM_RD_DATA;

    mips_core #(.RESET_PC(32'h0000_0000)) dut (
        .CLK        (CLK),
        .Z_R        (Z_R),
        .IM_ADDR    (IM_ADDR),
        .IM_DATA    (IM_DATA),
        .DM_WE      (DM_WE),
        .DM_ADDR    (DM_ADDR),
        .DM_WR_DATA (DM_WR_DATA),
        .DM_RD_DATA (DM_RD_DATA)
    );

    always #5 CLK = ~CLK;

    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:63];
    int          cyc = 0;
    int          pa  = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          m_cycles = 0;

    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];
    int          q_cyc  [$];
    logic [31:0] e_addr [$];
    logic [31:0] e_data [$];
    int          e_cyc  [$];

    function automatic logic [31:0] hw_read(input logic [31:0] a);
        return (a[31:8] == 24'd0) ? dmem[a[7:2]] : 32'hFFFF_FFFF;
    endfunction

    always @(posedge CLK) begin
        IM_DATA    <= (IM_ADDR[31:10] == 22'd0) ? imem[IM_ADDR[9:2]] : 32'h0;
        DM_RD_DATA <= hw_read(DM_ADDR);
        cyc        <= Z_R ? 0 : cyc + 1;
    end

    always @(negedge CLK) begin
        if (DM_WE) begin
            q_addr.push_back(DM_ADDR);
            q_data.push_back(DM_WR_DATA);
            q_cyc.push_back(cyc);
            if (DM_ADDR[31:8] == 24'd0) dmem[DM_ADDR[7:2]] = DM_WR_DATA;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_to(input int n);
        for (int k = 0; k < 1000 && cyc < n; k++) tick();
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] f, input int rs, input int rt, input int rd);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, rs[4:0], rt[4:0], imm};
    endfunction

    function automatic logic [31:0] enc_j(input int t);
        return {6'h02, t[25:0]};
    endfunction

    function automatic logic [31:0] st_data(input int i);
        return (i < q_data.size()) ? q_data[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] st_addr(input int i);
        return (i < q_addr.size()) ? q_addr[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic emit(input logic [31:0] w);
        imem[pa] = w;
        pa++;
    endtask

    task automatic emit_halt();
        emit(enc_j(pa));
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
        pa = 0;
    endtask

    task automatic do_reset(input bit chk);
        Z_R = 1'b1;
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
        tick();
        tick();
        if (chk) begin
            check("reset IM_ADDR", IM_ADDR, 32'h0);
            check("reset DM_WE", {31'd0, DM_WE}, 32'h0);
            check("reset DM_ADDR", DM_ADDR, 32'h0);
            check("reset DM_WR_DATA", DM_WR_DATA, 32'h0);
        end
        Z_R = 1'b0;
    endtask

    // Instruction-at-a-time ISA model: produces expected stores and their MEM cycle.
    task automatic model_run();
        logic [31:0] mrf [32];
        logic [31:0] mdm [64];
        logic [31:0] pc, nxt, ir, a, b, imm, val, ea;
        int dest, lat, t;
        bit ok;
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        for (int i = 0; i < 64; i++) mdm[i] = dmem[i];
        e_addr.delete();
        e_data.delete();
        e_cyc.delete();
        pc = 32'h0;
        t  = 0;
        for (int step = 0; step < 2000; step++) begin
            ir   = (pc[31:10] == 22'd0) ? imem[pc[9:2]] : 32'h0;
            nxt  = pc + 32'd4;
            a    = mrf[ir[25:21]];
            b    = mrf[ir[20:16]];
            imm  = {{16{ir[15]}}, ir[15:0]};
            dest = 0;
            val  = 32'h0;
            lat  = 3;
            if (ir[31:26] == 6'h02 && {nxt[31:28], ir[25:0], 2'b00} == pc) break;
            case (ir[31:26])
                6'h00: begin
                    ok = 1'b1;
                    case (ir[5:0])
                        6'h20:   val = a + b;
                        6'h22:   val = a - b;
                        6'h24:   val = a & b;
                        6'h25:   val = a | b;
                        6'h2A:   val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: ok = 1'b0;
                    endcase
                    if (ok) begin
                        dest = int'(ir[15:11]);
                        lat  = 4;
                    end
                end
                6'h08: begin
                    dest = int'(ir[20:16]);
                    val  = a + imm;
                    lat  = 4;
                end
                6'h23: begin
                    ea   = a + imm;
                    val  = (ea[31:8] == 24'd0) ? mdm[ea[7:2]] : 32'hFFFF_FFFF;
                    dest = int'(ir[20:16]);
                    lat  = 5;
                end
                6'h2B: begin
                    ea = a + imm;
                    e_addr.push_back(ea);
                    e_data.push_back(b);
                    e_cyc.push_back(t + 3);
                    if (ea[31:8] == 24'd0) mdm[ea[7:2]] = b;
                    lat = 4;
                end
                6'h04: if (a == b) nxt = nxt + (imm << 2);
                6'h02: nxt = {nxt[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
            if (dest != 0) mrf[dest] = val;
            t  = t + lat;
            pc = nxt;
        end
        m_cycles = t;
    endtask

    task automatic run_prog(input string name);
        model_run();
        do_reset(1'b0);
        wait_to(m_cycles + 8);
        check({name, " store count"}, 32'(q_addr.size()), 32'(e_addr.size()));
        for (int i = 0; i < e_addr.size() && i < q_addr.size(); i++) begin
            check($sformatf("%s st%0d addr", name, i), q_addr[i], e_addr[i]);
            check($sformatf("%s st%0d data", name, i), q_data[i], e_data[i]);
            check($sformatf("%s st%0d cycle", name, i), 32'(q_cyc[i]), 32'(e_cyc[i]));
        end
    endtask

    typedef struct {
        string       name;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{"add",       6'h20, 32'd5,         32'd7,         32'd12};
        vecs[1]  = '{"sub",       6'h22, 32'd5,         32'd7,         32'hFFFF_FFFE};
        vecs[2]  = '{"and",       6'h24, 32'd5,         32'd7,         32'd5};
        vecs[3]  = '{"or",        6'h25, 32'd5,         32'd7,         32'd7};
        vecs[4]  = '{"slt lt",    6'h2A, 32'd5,         32'd7,         32'd1};
        vecs[5]  = '{"slt ge",    6'h2A, 32'd7,         32'd5,         32'd0};
        vecs[6]  = '{"slt sgn",   6'h2A, 32'hFFFF_FFFF, 32'd1,         32'd1};
        vecs[7]  = '{"add wrap",  6'h20, 32'hFFFF_FFFF, 32'd2,         32'd1};
        vecs[8]  = '{"sub wrap",  6'h22, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF};
        vecs[9]  = '{"and mask",  6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[10] = '{"bad funct", 6'h21, 32'd5,         32'd7,         32'd0};

        clear_mem();
        do_reset(1'b1);

        // Release timing with a NOP at address 0.
        check("fetch c0", IM_ADDR, 32'h0);
        tick();
        check("fetch c1", IM_ADDR, 32'h0);
        tick();
        check("fetch c2", IM_ADDR, 32'h4);
        tick();
        check("fetch c3", IM_ADDR, 32'h4);

        clear_mem();
        emit(enc_i(6'h08, 0, 1, 16'd5));
        emit(enc_i(6'h08, 0, 2, 16'd7));
        emit(enc_r(6'h20, 1, 2, 3));
        emit(enc_i(6'h2B, 0, 3, 16'd8));
        emit_halt();
        run_prog("addi-add-sw");
        check("seq1 pulses", 32'(q_addr.size()), 32'd1);
        check("seq1 addr", st_addr(0), 32'd8);
        check("seq1 data", st_data(0), 32'd12);
        do_reset(1'b1);

        foreach (vecs[v]) begin
            clear_mem();
            dmem[0] = vecs[v].a;
            dmem[1] = vecs[v].b;
            emit(enc_i(6'h23, 0, 1, 16'd0));
            emit(enc_i(6'h23, 0, 2, 16'd4));
            emit(enc_r(vecs[v].funct, 1, 2, 3));
            emit(enc_i(6'h2B, 0, 3, 16'd8));
            emit_halt();
            run_prog(vecs[v].name);
            check({vecs[v].name, " result"}, st_data(0), vecs[v].exp);
        end

        clear_mem();
        dmem[1] = 32'hDEAD_BEEF;
        emit(enc_i(6'h23, 0, 4, 16'd4));
        emit(enc_i(6'h2B, 0, 4, 16'd12));
        emit(enc_i(6'h23, 0, 5, 16'h0400));
        emit(enc_i(6'h2B, 0, 5, 16'd16));
        emit_halt();
        run_prog("lw-sw");
        check("lw addr", st_addr(0), 32'd12);
        check("lw data", st_data(0), 32'hDEAD_BEEF);
        check("lw unmapped", st_data(1), 32'hFFFF_FFFF);

        clear_mem();
        emit(enc_i(6'h2B, 0, 4, 16'd0));
        emit_halt();
        run_prog("gpr reset");
        check("gpr cleared", st_data(0), 32'h0);

        clear_mem();
        emit(enc_i(6'h08, 0, 0, 16'd9));
        emit(enc_i(6'h2B, 0, 0, 16'd0));
        emit_halt();
        run_prog("r0 write");
        check("r0 stays 0", st_data(0), 32'h0);

        // beq taken at 0x10 after four NOPs.
        clear_mem();
        imem[4] = enc_i(6'h04, 0, 0, 16'd2);
        imem[5] = enc_i(6'h08, 0, 1, 16'd1);
        imem[6] = enc_i(6'h08, 0, 1, 16'd2);
        imem[7] = enc_i(6'h2B, 0, 1, 16'h20);
        imem[8] = enc_j(8);
        do_reset(1'b0);
        wait_to(14);
        check("beq pc+4", IM_ADDR, 32'h14);
        tick();
        check("beq taken", IM_ADDR, 32'h1C);
        run_prog("beq taken");
        check("beq skipped", st_data(0), 32'h0);

        clear_mem();
        emit(enc_i(6'h08, 0, 1, 16'd5));
        emit(enc_i(6'h04, 1, 0, 16'd2));
        emit(enc_i(6'h08, 0, 2, 16'd3));
        emit(enc_i(6'h08, 2, 2, 16'd4));
        emit(enc_i(6'h2B, 0, 2, 16'd0));
        emit_halt();
        do_reset(1'b0);
        wait_to(7);
        check("beq not taken", IM_ADDR, 32'h8);
        run_prog("beq fall");
        check("beq fall data", st_data(0), 32'd7);

        clear_mem();
        imem[0]    = enc_j(32'h40);
        imem[8'h40] = enc_j(32'h40);
        do_reset(1'b0);
        wait_to(2);
        check("j pc+4", IM_ADDR, 32'h4);
        tick();
        check("j target", IM_ADDR, 32'h100);

        // Reset arrives in the MEM cycle of a store.
        clear_mem();
        dmem[4] = 32'h1234_5678;
        emit(enc_i(6'h08, 0, 1, 16'd5));
        emit(enc_i(6'h2B, 0, 1, 16'd16));
        emit_halt();
        do_reset(1'b0);
        wait_to(7);
        check("sw MEM we", {31'd0, DM_WE}, 32'd1);
        Z_R = 1'b1;
        #1;
        check("abort we", {31'd0, DM_WE}, 32'd0);
        tick();
        check("abort pc", IM_ADDR, 32'h0);
        check("abort mem", dmem[4], 32'h1234_5678);
        check("abort pulses", 32'(q_addr.size()), 32'd0);
        Z_R = 1'b0;

        for (int it = 0; it < 12; it++) begin
            clear_mem();
            for (int i = 0; i < 8; i++) dmem[i] = $urandom;
            for (int r = 1; r <= 4; r++) emit(enc_i(6'h23, 0, r, 16'(4 * (r - 1))));
            for (int n = 0; n < 14; n++) begin
                int kind;
                logic [5:0] fn;
                kind = $urandom_range(0, 7);
                case ($urandom_range(0, 4))
                    0: fn = 6'h20;
                    1: fn = 6'h22;
                    2: fn = 6'h24;
                    3: fn = 6'h25;
                    default: fn = 6'h2A;
                endcase
                if (kind <= 4)
                    emit(enc_r(fn, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
                else if (kind == 5)
                    emit(enc_i(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom)));
                else if (kind == 6)
                    emit(enc_i(6'h04, $urandom_range(0, 7), $urandom_range(0, 7), 16'd1));
                else
                    emit(enc_i(6'h3F, 1, 2, 16'($urandom)));
            end
            for (int r = 1; r <= 7; r++) emit(enc_i(6'h2B, 0, r, 16'(32'h40 + 4 * r)));
            emit_halt();
            run_prog($sformatf("rand%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
